lsu_mmio_pipe: RTL and testbench
================================

// Module: lsu_mmio_pipe
// PURPOSE
// - RV32I load/store unit: parametrised word RAM plus memory-mapped I/O (LEDs, hex, LCD, switches).
// - Sits between the execute stage and data memory/board I/O; handles LB/LH/LW/LBU/LHU/SB/SH/SW.
// - valid/ready request handshake with a single-cycle response pulse.
// - Synchronous-read RAM; misaligned accesses split into two RAM beats by an FSM.
// PARAMETERS
// - MEM_DEPTH  512            RAM words; power of 2; RAM occupies byte addrs [0, MEM_DEPTH*4)
// - IO_BASE    32'h0000_7000  MMIO base (4 KiB window)
// - NUM_HEX    8              hex digits, 1..8
// PORTS
// - i_clk        in   1          clock, rising edge
// - i_reset      in   1          synchronous active-low reset
// - i_req_valid  in   1          request present
// - o_req_ready  out  1          =1 only in IDLE and reset deasserted
// - i_req_we     in   1          1=store, 0=load
// - i_funct3     in   3          RV32I load/store funct3
// - i_addr       in   32         byte address
// - i_st_data    in   32         store data, right-aligned
// - o_rsp_valid  out  1          one-cycle completion pulse (loads and stores)
// - o_ld_data    out  32         load result, valid with o_rsp_valid, else 0
// - o_misaligned out  1          with o_rsp_valid: access was rejected as misaligned
// - i_io_sw      in   32         switch inputs
// - o_io_ledr    out  32         red LEDs
// - o_io_ledg    out  32         green LEDs
// - o_io_lcd     out  32         LCD control word
// - o_io_hex     out  NUM_HEX*7  digit k = bits [7k+6:7k], segments active-low
// BEHAVIOUR
// - Handshake: accept when i_req_valid && o_req_ready; latch funct3/addr/data/we.
//   Inputs are ignored while busy; o_rsp_valid has no backpressure.
// - FSM states: IDLE, BEAT2, RESP.
//   - Aligned access, or any MMIO access: IDLE -> RESP.
//   - Split access: IDLE -> BEAT2 -> RESP.
//   - RESP -> IDLE; o_rsp_valid=1 in RESP only.
// - Latency: aligned = accept cycle N, rsp at N+1; split = rsp at N+2; throughput 1 req per 2/3 cycles.
// - Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
// - RAM: word index = addr[log2(MEM_DEPTH)+1:2]; writes use per-byte enables (no read-modify-write).
//   - Split beat 2 index = (idx+1) mod MEM_DEPTH, so the last word wraps to word 0.
//   - Beat 1 carries the low bytes, beat 2 the high bytes.
// - Loads: byte/half extracted at addr[1:0] (across the word boundary for split loads).
//   - LB/LH sign-extend; LBU/LHU zero-extend.
//   - Illegal funct3 (011, 11x): load returns 0, store writes nothing; rsp still issued.
// - MMIO offsets from IO_BASE (word registers):
//   - 0x000 ledr, 0x010 ledg, 0x030 lcd.
//   - 0x100+4k hex k (low 7 bits stored).
//   - 0x800 sw (read-only).
//   - Sub-word stores merge only the addressed bytes.
//   - Misaligned MMIO access is always rejected: o_misaligned=1, no write, load data 0.
// - Unmapped address: load returns 0, store dropped, o_misaligned=0, rsp issued normally.
// - Reset (i_reset=0 at a posedge):
//   - FSM -> IDLE; o_rsp_valid=0, o_ld_data=0, o_misaligned=0.
//   - ledr/ledg/lcd=0; every hex digit=7'h7F (blank).
//   - RAM contents undefined/not cleared.
//   - Mid-split reset aborts beat 2; a beat-1 write already performed stays committed.
//   - o_req_ready=0 while reset is asserted.
// CONFIGURATION
// - LSU_MISALIGN_SPLIT_EN defined: misaligned RAM accesses split into two beats as above; o_misaligned never set for RAM.
// - Undefined: BEAT2 unreachable.
//   - Misaligned RAM access -> RESP at N+1 with o_misaligned=1, no write, o_ld_data=0.
// TESTING
// - Reset then SW 0x11223344 @0x10; LW @0x10 -> o_ld_data=0x11223344 exactly 1 cycle after accept; o_req_ready=0 in RESP.
// - SB 0x80 @0x13; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80223344.
// - SPLIT_EN: SW 0xAABBCCDD @0x7FE (MEM_DEPTH=512) -> wraps.
//   - LW @0x7FC -> 0xCCDDxxxx; LHU @0x0 -> 0xAABB; rsp 2 cycles after accept.
//   - Without SPLIT_EN: o_misaligned=1, memory unchanged.
// - SW 0x5 @IO_BASE+0x000 -> o_io_ledr=5 after RESP; SB 0x40 @IO_BASE+0x104 -> hex1=7'h40.
//   - i_io_sw=0xF0F0F0F0, LH @IO_BASE+0x800 -> 0xFFFFF0F0.
// - Split SH accept, i_reset=0 in BEAT2 -> only beat-1 byte written, o_rsp_valid stays 0, hex=7'h7F, leds=0.
// - LW @0x4000 (unmapped) -> 0 with o_misaligned=0; SW @IO_BASE+0x2 -> o_misaligned=1, ledr unchanged.

Source files
------------

// File: rtl/lsu_mmio_pipe.sv
// lsu_mmio_pipe: RV32I load/store unit in front of a sync-read word RAM and board MMIO.
// Optional feature macro LSU_MISALIGN_SPLIT_EN: misaligned RAM accesses are split into
// two RAM beats (low bytes first). When the macro is undefined they are rejected.
module lsu_mmio_pipe #(
  parameter int unsigned MEM_DEPTH = 512,
  parameter logic [31:0] IO_BASE   = 32'h0000_7000,
  parameter int unsigned NUM_HEX   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_we,
  input  logic [2:0]           i_funct3,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_st_data,
  output logic                 o_rsp_valid,
  output logic [31:0]          o_ld_data,
  output logic                 o_misaligned,
  input  logic [31:0]          i_io_sw,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [31:0]          o_io_lcd,
  output logic [NUM_HEX*7-1:0] o_io_hex
);
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(MEM_DEPTH) << 2;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BEAT2, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              f3_q, f3_d;
  logic [1:0]              off_q, off_d;
  logic                    zero_q, zero_d, mis_q, mis_d, split_q, split_d, io_ld_q, io_ld_d;
  logic [31:0]             io_rd_q, io_rd_d, lo_q, lo_d, st_hi_q, st_hi_d;
  logic [3:0]              be_hi_q, be_hi_d;
  logic [IDX_W-1:0]        idx2_q, idx2_d;
  logic [31:0]             ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
  logic [NUM_HEX-1:0][6:0] hex_q, hex_d;

  logic [31:0]      mem [MEM_DEPTH];
  logic [31:0]      ram_rd_q;
  logic [IDX_W-1:0] ram_idx_c;
  logic [31:0]      ram_wd_c;
  logic [3:0]       ram_be_c;

  logic        accept_c, legal_c, mis_c, in_ram_c, in_io_c, split_c, reject_c, io_wr_c;
  logic [3:0]  mask_c;
  logic [7:0]  be8_c;
  logic [63:0] st64_c;
  logic [9:0]  io_word_c;
  logic [31:0] io_cur_c, io_new_c;
  logic [63:0] ld_pair_c;
  logic [31:0] ld_sh_c, ld_ext_c;

  assign o_req_ready  = (state_q == S_IDLE) && i_reset;
  assign accept_c     = i_req_valid && o_req_ready;
  assign o_rsp_valid  = (state_q == S_RESP);
  assign o_misaligned = (state_q == S_RESP) && mis_q;
  assign o_ld_data    = ((state_q == S_RESP) && !zero_q) ? ld_ext_c : 32'h0;
  assign o_io_ledr    = ledr_q;
  assign o_io_ledg    = ledg_q;
  assign o_io_lcd     = lcd_q;
  assign o_io_hex     = hex_q;

  // Request decode: legality, alignment, region and byte lanes of the incoming access
  always_comb begin
    legal_c = !((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11));
    mis_c = legal_c && (((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00)));
    in_ram_c  = {1'b0, i_addr} < RAM_BYTES;
    in_io_c   = i_addr[31:12] == IO_BASE[31:12];
    split_c   = SPLIT_EN && in_ram_c && mis_c;
    reject_c  = mis_c && (in_io_c || (in_ram_c && !SPLIT_EN));
    mask_c    = 4'b0000;
    if (legal_c) begin
      case (i_funct3[1:0])
        2'b00:   mask_c = 4'b0001;
        2'b01:   mask_c = 4'b0011;
        2'b10:   mask_c = 4'b1111;
        default: mask_c = 4'b0000;
      endcase
    end
    be8_c     = 8'(mask_c) << i_addr[1:0];
    st64_c    = 64'(i_st_data) << {i_addr[1:0], 3'b000};
    io_word_c = i_addr[11:2];
    io_wr_c   = accept_c && i_req_we && in_io_c && !mis_c;
  end

  // MMIO register read and byte-merged write value for the addressed word
  always_comb begin
    io_cur_c = 32'h0;
    case (io_word_c)
      10'h000: io_cur_c = ledr_q;
      10'h004: io_cur_c = ledg_q;
      10'h00C: io_cur_c = lcd_q;
      10'h200: io_cur_c = i_io_sw;
      default: io_cur_c = 32'h0;
    endcase
    for (int k = 0; k < NUM_HEX; k++) begin
      if (io_word_c == 10'(32'h40 + k)) io_cur_c = {25'h0, hex_q[k]};
    end
    for (int b = 0; b < 4; b++) begin
      io_new_c[8*b +: 8] = be8_c[b] ? st64_c[8*b +: 8] : io_cur_c[8*b +: 8];
    end
  end

  // RAM port: beat 1 from the live request, beat 2 from latched high lanes
  always_comb begin
    ram_idx_c = i_addr[IDX_W+1:2];
    ram_wd_c  = st64_c[31:0];
    ram_be_c  = 4'b0000;
    if (state_q == S_BEAT2) begin
      ram_idx_c = idx2_q;
      ram_wd_c  = st_hi_q;
      if (i_reset) ram_be_c = be_hi_q;
    end else if (accept_c && i_req_we && in_ram_c && !reject_c) begin
      ram_be_c = be8_c[3:0];
    end
  end

  // Next state, request latch and MMIO writes
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    off_d   = off_q;
    zero_d  = zero_q;
    mis_d   = mis_q;
    split_d = split_q;
    io_ld_d = io_ld_q;
    io_rd_d = io_rd_q;
    lo_d    = lo_q;
    st_hi_d = st_hi_q;
    be_hi_d = be_hi_q;
    idx2_d  = idx2_q;
    ledr_d  = ledr_q;
    ledg_d  = ledg_q;
    lcd_d   = lcd_q;
    hex_d   = hex_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = split_c ? S_BEAT2 : S_RESP;
          f3_d    = i_funct3;
          off_d   = i_addr[1:0];
          split_d = split_c;
          mis_d   = reject_c;
          io_ld_d = in_io_c;
          zero_d  = i_req_we || !legal_c || reject_c || !(in_ram_c || in_io_c);
          io_rd_d = io_cur_c;
          idx2_d  = i_addr[IDX_W+1:2] + IDX_W'(1);
          st_hi_d = st64_c[63:32];
          be_hi_d = (i_req_we && split_c) ? be8_c[7:4] : 4'b0000;
          if (io_wr_c) begin
            case (io_word_c)
              10'h000: ledr_d = io_new_c;
              10'h004: ledg_d = io_new_c;
              10'h00C: lcd_d  = io_new_c;
              default: ;
            endcase
            for (int k = 0; k < NUM_HEX; k++) begin
              if (io_word_c == 10'(32'h40 + k)) hex_d[k] = io_new_c[6:0];
            end
          end
        end
      end
      S_BEAT2: begin
        lo_d    = ram_rd_q;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load result: join split beats, align to byte offset, then extend
  always_comb begin
    ld_pair_c = split_q ? {ram_rd_q, lo_q} : {32'h0, (io_ld_q ? io_rd_q : ram_rd_q)};
    ld_sh_c   = 32'(ld_pair_c >> {off_q, 3'b000});
    case (f3_q)
      3'b000:  ld_ext_c = {{24{ld_sh_c[7]}}, ld_sh_c[7:0]};
      3'b001:  ld_ext_c = {{16{ld_sh_c[15]}}, ld_sh_c[15:0]};
      3'b010:  ld_ext_c = ld_sh_c;
      3'b100:  ld_ext_c = {24'h0, ld_sh_c[7:0]};
      3'b101:  ld_ext_c = {16'h0, ld_sh_c[15:0]};
      default: ld_ext_c = 32'h0;
    endcase
  end

  // Word RAM with per-byte write enables and registered read; contents never reset
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_be_c[b]) mem[ram_idx_c][8*b +: 8] <= ram_wd_c[8*b +: 8];
    end
    ram_rd_q <= mem[ram_idx_c];
  end

  // State and register update with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      zero_q  <= 1'b0;
      mis_q   <= 1'b0;
      split_q <= 1'b0;
      io_ld_q <= 1'b0;
      io_rd_q <= 32'h0;
      lo_q    <= 32'h0;
      st_hi_q <= 32'h0;
      be_hi_q <= 4'b0000;
      idx2_q  <= '0;
      ledr_q  <= 32'h0;
      ledg_q  <= 32'h0;
      lcd_q   <= 32'h0;
      hex_q   <= {NUM_HEX{7'h7F}};
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      zero_q  <= zero_d;
      mis_q   <= mis_d;
      split_q <= split_d;
      io_ld_q <= io_ld_d;
      io_rd_q <= io_rd_d;
      lo_q    <= lo_d;
      st_hi_q <= st_hi_d;
      be_hi_q <= be_hi_d;
      idx2_q  <= idx2_d;
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
      lcd_q   <= lcd_d;
      hex_q   <= hex_d;
    end
  end

endmodule

// File: tb/tb_lsu_mmio_pipe.sv
// tb_lsu_mmio_pipe: directed and randomized checks of lsu_mmio_pipe against a byte-level model.
// Honours LSU_MISALIGN_SPLIT_EN the same way as the design.
module tb_lsu_mmio_pipe;
  localparam int unsigned MEM_DEPTH = 512;
  localparam int unsigned RAM_BYTES = MEM_DEPTH * 4;
  localparam logic [31:0] IO_BASE   = 32'h0000_7000;
  localparam int unsigned NUM_HEX   = 8;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic                 i_clk = 1'b0;
  logic                 i_reset;
  logic                 i_req_valid;
  logic                 o_req_ready;
  logic                 i_req_we;
  logic [2:0]           i_funct3;
  logic [31:0]          i_addr;
  logic [31:0]          i_st_data;
  logic                 o_rsp_valid;
  logic [31:0]          o_ld_data;
  logic                 o_misaligned;
  logic [31:0]          i_io_sw;
  logic [31:0]          o_io_ledr;
  logic [31:0]          o_io_ledg;
  logic [31:0]          o_io_lcd;
  logic [NUM_HEX*7-1:0] o_io_hex;

  always #5 i_clk = ~i_clk;

  lsu_mmio_pipe #(.MEM_DEPTH(MEM_DEPTH), .IO_BASE(IO_BASE), .NUM_HEX(NUM_HEX)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_st_data(i_st_data),
    .o_rsp_valid(o_rsp_valid), .o_ld_data(o_ld_data), .o_misaligned(o_misaligned),
    .i_io_sw(i_io_sw), .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg), .o_io_lcd(o_io_lcd),
    .o_io_hex(o_io_hex)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_mem [RAM_BYTES];
  logic [31:0] m_ledr, m_ledg, m_lcd;
  logic [6:0]  m_hex [NUM_HEX];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int f3_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_io_read(input logic [31:0] off);
    if (off >= 32'h100 && off < 32'h100 + 4 * NUM_HEX) return {25'h0, m_hex[(off - 32'h100) / 4]};
    case (off)
      32'h000: return m_ledr;
      32'h010: return m_ledg;
      32'h030: return m_lcd;
      32'h800: return i_io_sw;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_io_write(input logic [31:0] off, input logic [31:0] w);
    if (off >= 32'h100 && off < 32'h100 + 4 * NUM_HEX) m_hex[(off - 32'h100) / 4] = w[6:0];
    else if (off == 32'h000) m_ledr = w;
    else if (off == 32'h010) m_ledg = w;
    else if (off == 32'h030) m_lcd = w;
  endtask

  task automatic model_reset();
    m_ledr = 32'h0;
    m_ledg = 32'h0;
    m_lcd  = 32'h0;
    for (int k = 0; k < NUM_HEX; k++) m_hex[k] = 7'h7F;
  endtask

  // Applies one access to the model; beat1_only keeps only bytes within the first word
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input bit beat1_only,
                       output logic [31:0] e_ld, output logic e_mis, output int e_lat);
    int n;
    bit ram, io, mis, rej;
    logic [31:0] v, w, off, woff;
    int unsigned a;
    n    = f3_size(f3);
    ram  = addr < RAM_BYTES;
    io   = (addr >> 12) == (IO_BASE >> 12);
    mis  = 1'b0;
    if (n != 0) mis = (addr % n) != 0;
    e_lat = (ram && mis && SPLIT) ? 2 : 1;
    rej   = mis && (io || (ram && !SPLIT));
    e_mis = rej;
    e_ld  = 32'h0;
    v     = 32'h0;
    if (n == 0 || rej || !(ram || io)) return;
    if (ram) begin
      for (int i = 0; i < n; i++) begin
        a = (addr + i) % RAM_BYTES;
        if (we) begin
          if (!beat1_only || ((addr + i) / 4 == addr / 4)) m_mem[a] = data[8*i +: 8];
        end else begin
          v[8*i +: 8] = m_mem[a];
        end
      end
    end else begin
      off  = addr - IO_BASE;
      woff = {off[31:2], 2'b00};
      w    = m_io_read(woff);
      if (we) begin
        for (int i = 0; i < n; i++) w[8*(off[1:0] + i) +: 8] = data[8*i +: 8];
        m_io_write(woff, w);
      end else begin
        v = w >> (8 * off[1:0]);
      end
    end
    if (!we) begin
      case (f3)
        3'b000:  e_ld = {{24{v[7]}}, v[7:0]};
        3'b001:  e_ld = {{16{v[15]}}, v[15:0]};
        3'b010:  e_ld = v;
        3'b100:  e_ld = {24'h0, v[7:0]};
        3'b101:  e_ld = {16'h0, v[15:0]};
        default: e_ld = 32'h0;
      endcase
    end
  endtask

  task automatic check_io();
    logic [NUM_HEX*7-1:0] eh;
    for (int k = 0; k < NUM_HEX; k++) eh[7*k +: 7] = m_hex[k];
    check("ledr", 64'(o_io_ledr), 64'(m_ledr));
    check("ledg", 64'(o_io_ledg), 64'(m_ledg));
    check("lcd",  64'(o_io_lcd),  64'(m_lcd));
    check("hex",  64'(o_io_hex),  64'(eh));
  endtask

  // One full transaction; returns at the negedge inside the response cycle
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] data, output logic [31:0] ld);
    logic [31:0] e_ld;
    logic        e_mis;
    int          e_lat, lat;
    for (int k = 0; k < 8 && !o_req_ready; k++) @(negedge i_clk);
    check("ready_idle", 64'(o_req_ready), 64'(1));
    check("ld_idle", 64'(o_ld_data), 64'(0));
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_funct3    = f3;
    i_addr      = addr;
    i_st_data   = data;
    @(posedge i_clk);
    #1;
    model(we, f3, addr, data, 1'b0, e_ld, e_mis, e_lat);
    i_req_we  = 1'($urandom);
    i_funct3  = 3'($urandom);
    i_addr    = $urandom;
    i_st_data = $urandom;
    lat = 0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge i_clk);
      if (o_rsp_valid) lat = k;
    end
    i_req_valid = 1'b0;
    check("latency", 64'(lat), 64'(e_lat));
    check("misaligned", 64'(o_misaligned), 64'(e_mis));
    check("ld_data", 64'(o_ld_data), 64'(e_ld));
    check("ready_resp", 64'(o_req_ready), 64'(0));
    check_io();
    ld = o_ld_data;
  endtask

  // Accept a request, then assert reset in the following cycle
  task automatic txn_abort(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data);
    logic [31:0] e_ld;
    logic        e_mis;
    int          e_lat;
    for (int k = 0; k < 8 && !o_req_ready; k++) @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_funct3    = f3;
    i_addr      = addr;
    i_st_data   = data;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    model(we, f3, addr, data, 1'b1, e_ld, e_mis, e_lat);
    @(negedge i_clk);
    check("abort_first_rsp", 64'(o_rsp_valid), 64'(e_lat == 1));
    i_reset = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      check("abort_rsp", 64'(o_rsp_valid), 64'(0));
      check("abort_ready", 64'(o_req_ready), 64'(0));
    end
    check_io();
    i_reset = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    logic [31:0] ld, a, d, off;
    logic        we;
    logic [2:0]  f3;
    int          r, sel;
    i_reset     = 1'b0;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_funct3    = 3'b000;
    i_addr      = 32'h0;
    i_st_data   = 32'h0;
    i_io_sw     = 32'h0;
    model_reset();
    repeat (3) @(negedge i_clk);
    check("rst_ready", 64'(o_req_ready), 64'(0));
    check("rst_rsp", 64'(o_rsp_valid), 64'(0));
    check("rst_ld", 64'(o_ld_data), 64'(0));
    check("rst_mis", 64'(o_misaligned), 64'(0));
    check_io();
    i_reset = 1'b1;
    @(negedge i_clk);

    for (int w = 0; w < MEM_DEPTH; w++) txn(1'b1, 3'b010, 32'(w * 4), $urandom, ld);

    txn(1'b1, 3'b010, 32'h10, 32'h11223344, ld);
    txn(1'b0, 3'b010, 32'h10, 32'h0, ld);
    check("lw_10", 64'(ld), 64'(32'h11223344));
    txn(1'b1, 3'b000, 32'h13, 32'h80, ld);
    txn(1'b0, 3'b000, 32'h13, 32'h0, ld);
    check("lb_13", 64'(ld), 64'(32'hFFFFFF80));
    txn(1'b0, 3'b100, 32'h13, 32'h0, ld);
    check("lbu_13", 64'(ld), 64'(32'h00000080));
    txn(1'b0, 3'b010, 32'h10, 32'h0, ld);
    check("lw_10_merged", 64'(ld), 64'(32'h80223344));

    txn(1'b1, 3'b010, 32'h7FE, 32'hAABBCCDD, ld);
    txn(1'b0, 3'b010, 32'h7FC, 32'h0, ld);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("lw_7fc_hi", 64'(ld[31:16]), 64'(16'hCCDD));
    txn(1'b0, 3'b101, 32'h0, 32'h0, ld);
    check("lhu_0_wrap", 64'(ld), 64'(32'h0000AABB));
`endif

    txn(1'b1, 3'b010, IO_BASE, 32'h5, ld);
    check("ledr_5", 64'(o_io_ledr), 64'(5));
    txn(1'b1, 3'b000, IO_BASE + 32'h104, 32'h40, ld);
    check("hex1", 64'(o_io_hex[13:7]), 64'(7'h40));
    i_io_sw = 32'hF0F0F0F0;
    txn(1'b0, 3'b001, IO_BASE + 32'h800, 32'h0, ld);
    check("lh_sw", 64'(ld), 64'(32'hFFFFF0F0));
    txn(1'b0, 3'b010, 32'h4000, 32'h0, ld);
    check("unmapped_ld", 64'(ld), 64'(0));
    check("unmapped_mis", 64'(o_misaligned), 64'(0));
    txn(1'b1, 3'b010, IO_BASE + 32'h2, 32'h12345678, ld);
    check("io_mis", 64'(o_misaligned), 64'(1));
    check("ledr_kept", 64'(o_io_ledr), 64'(5));

    txn_abort(1'b1, 3'b001, 32'h13, 32'h0000BEEF);
    txn(1'b0, 3'b100, 32'h13, 32'h0, ld);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("abort_beat1", 64'(ld), 64'(32'hEF));
`endif
    txn(1'b0, 3'b100, 32'h14, 32'h0, ld);

    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        a = $urandom_range(0, RAM_BYTES - 1);
      end else if (r < 8) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0:       off = 32'h000;
          1:       off = 32'h010;
          2:       off = 32'h030;
          3:       off = 32'h100 + 4 * $urandom_range(0, NUM_HEX - 1);
          4:       off = 32'h800;
          default: off = 32'h020;
        endcase
        a = IO_BASE + off + $urandom_range(0, 3);
      end else if (r == 8) begin
        a = 32'h4000 + ($urandom & 32'hFFF);
      end else begin
        a = RAM_BYTES - 4 + $urandom_range(0, 3);
      end
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (we && (f3 == 3'b100 || f3 == 3'b101)) f3 = f3 - 3'd4;
      d = $urandom;
      i_io_sw = $urandom;
      txn(we, f3, a, d, ld);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
